// File: rtl/seq_divider_pkg.sv
// Shared definitions for the sequential divider: FSM state encoding and default width.
package seq_divider_pkg;

  localparam int DEFAULT_N = 16;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/seq_divider_div_step.sv
// div_step: one restoring-division iteration (shift in dividend msb, trial subtract divisor).
module div_step
  import seq_divider_pkg::*;
#(
  parameter int N = DEFAULT_N
) (
  input  logic [N-1:0] p,
  input  logic         d_msb,
  input  logic [N-1:0] b,
  output logic [N-1:0] p_next,
  output logic         qbit
);

  logic [N:0]   t;
  logic [N:0]   bn;
  logic [N+1:0] c;
  logic [N-1:0] diff;

  // T is N+1 bits so the shifted remainder never truncates; only the low N bits
  // of T-B are kept since a restored remainder is always below B.
  always_comb begin
    t    = {p, d_msb};
    bn   = ~{1'b0, b};
    c    = '0;
    diff = '0;
    c[0] = 1'b1;
    for (int unsigned i = 0; i <= N; i++) begin
      if (i < N) diff[i] = t[i] ^ bn[i] ^ c[i];
      c[i+1] = (t[i] & bn[i]) | (t[i] & c[i]) | (bn[i] & c[i]);
    end
    qbit   = c[N+1];
    p_next = qbit ? diff : t[N-1:0];
  end

endmodule

// File: rtl/seq_divider.sv
// seq_divider: radix-2 restoring divider, 2N/N -> 2N quotient + N remainder, one bit per clock.
// Optional macro SEQ_DIV_DZ_FASTPATH_EN: divide-by-zero completes on the accepting edge.
module seq_divider
  import seq_divider_pkg::*;
#(
  parameter int N = DEFAULT_N
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           start,
  input  logic [2*N-1:0] a,
  input  logic [N-1:0]   b,
  output logic           busy,
  output logic           done,
  output logic [2*N-1:0] q,
  output logic [N-1:0]   r,
  output logic           dz
);

  localparam int CNT_W = $clog2(2*N);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(2*N-1);

  state_t           state, state_next;
  logic [CNT_W-1:0] cnt;
  logic [2*N-1:0]   d;
  logic [N-1:0]     bq;
  logic [N-1:0]     p;
  logic [N-1:0]     p_next;
  logic             qbit;
  logic             accept;
  logic             fast;

  div_step #(.N(N)) u_step (
    .p      (p),
    .d_msb  (d[2*N-1]),
    .b      (bq),
    .p_next (p_next),
    .qbit   (qbit)
  );

  assign accept = start && (state == S_IDLE || state == S_DONE);
`ifdef SEQ_DIV_DZ_FASTPATH_EN
  assign fast = accept && (b == '0);
`else
  assign fast = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE, S_DONE: begin
        if (start)                state_next = fast ? S_DONE : S_BUSY;
        else if (state == S_DONE) state_next = S_IDLE;
      end
      S_BUSY:  if (cnt == LAST) state_next = S_DONE;
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
      d   <= '0;
      bq  <= '0;
      p   <= '0;
      q   <= '0;
      r   <= '0;
      dz  <= 1'b0;
    end else if (accept) begin
      d   <= a;
      bq  <= b;
      p   <= '0;
      cnt <= '0;
      if (fast) begin
        q  <= '1;
        r  <= a[N-1:0];
        dz <= 1'b1;
      end
    end else if (state == S_BUSY) begin
      p   <= p_next;
      d   <= {d[2*N-2:0], qbit};
      cnt <= cnt + CNT_W'(1);
      if (cnt == LAST) begin
        q  <= {d[2*N-2:0], qbit};
        r  <= p_next;
        dz <= (bq == '0);
      end
    end
  end

  assign busy = (state == S_BUSY);
  assign done = (state == S_DONE);

endmodule
